// File: rtl/tetris_board_if.sv
// Piece-square, lock and display-read bundle between the piece controller and the board.
// Inputs are sampled at each pclk edge; no backpressure, locks arriving while busy are dropped.
interface tetris_board_if #(parameter int COLS = 10);
    logic [4:0]      sq_1_col, sq_2_col, sq_3_col, sq_4_col;
    logic [4:0]      sq_1_row, sq_2_row, sq_3_row, sq_4_row;
    logic            lock_en;
    logic [4:0]      rd_row;
    logic [COLS-1:0] rd_data;
    logic            collision;
    logic            busy;
    logic            line_pulse;
    logic [9:0]      lines_cleared;
    logic            game_over;

    modport master (
        output sq_1_col, sq_2_col, sq_3_col, sq_4_col,
        output sq_1_row, sq_2_row, sq_3_row, sq_4_row,
        output lock_en, rd_row,
        input  rd_data, collision, busy, line_pulse, lines_cleared, game_over
    );

    modport slave (
        input  sq_1_col, sq_2_col, sq_3_col, sq_4_col,
        input  sq_1_row, sq_2_row, sq_3_row, sq_4_row,
        input  lock_en, rd_row,
        output rd_data, collision, busy, line_pulse, lines_cleared, game_over
    );
endinterface

// File: rtl/tetris_board.sv
// Occupancy grid: 1-cycle collision/read, lock then bottom-up full-row removal (ROWS+1+clears cycles).
// No backpressure: lock_en while busy is discarded.
module tetris_board #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic          pclk,
    input  logic          rst,
    tetris_board_if.slave bus
);
    localparam int         CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int         RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [4:0] COLS_L = 5'(COLS);
    localparam logic [5:0] ROWS_L = 6'(ROWS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_nxt;
    logic [COLS-1:0] board [ROWS];
    logic [4:0]      scan_row;
    logic [4:0]      sq_col [4];
    logic [4:0]      sq_row [4];
    logic            do_lock, do_shift, do_dec;
    logic            row_full, hit;
    logic [5:0]      below;
    logic [COLS-1:0] rd_data_q;
    logic            collision_q, line_pulse_q, game_over_q;
    logic [9:0]      lines_q;

    assign sq_col[0] = bus.sq_1_col;
    assign sq_col[1] = bus.sq_2_col;
    assign sq_col[2] = bus.sq_3_col;
    assign sq_col[3] = bus.sq_4_col;
    assign sq_row[0] = bus.sq_1_row;
    assign sq_row[1] = bus.sq_2_row;
    assign sq_row[2] = bus.sq_3_row;
    assign sq_row[3] = bus.sq_4_row;

    assign row_full = &board[scan_row[RW-1:0]];

    // Squares in off-board columns are ignored; anything resting on the floor collides.
    always_comb begin
        hit   = 1'b0;
        below = '0;
        for (int i = 0; i < 4; i++) begin
            below = {1'b0, sq_row[i]} + 6'd1;
            if (sq_col[i] < COLS_L) begin
                if (below >= ROWS_L)
                    hit = 1'b1;
                else if (board[below[RW-1:0]][sq_col[i][CW-1:0]])
                    hit = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_lock   = 1'b0;
        do_shift  = 1'b0;
        do_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.lock_en) begin
                    do_lock   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (row_full)
                    do_shift = 1'b1;
                else if (scan_row == 5'd0)
                    state_nxt = DONE;
                else
                    do_dec = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                board[r] <= '0;
            scan_row     <= '0;
            rd_data_q    <= '0;
            collision_q  <= 1'b0;
            line_pulse_q <= 1'b0;
            lines_q      <= '0;
            game_over_q  <= 1'b0;
        end else begin
            collision_q  <= hit;
            line_pulse_q <= do_shift;
            rd_data_q    <= ({1'b0, bus.rd_row} < ROWS_L) ? board[bus.rd_row[RW-1:0]] : '0;

            if (do_lock) begin
                for (int i = 0; i < 4; i++)
                    if (sq_col[i] < COLS_L && {1'b0, sq_row[i]} < ROWS_L)
                        board[sq_row[i][RW-1:0]][sq_col[i][CW-1:0]] <= 1'b1;
                scan_row <= 5'(ROWS - 1);
            end

            // scan_row stays put so the row shifted down into it is examined next.
            if (do_shift) begin
                for (int r = 1; r < ROWS; r++)
                    if (5'(r) <= scan_row)
                        board[r] <= board[r-1];
                board[0] <= '0;
                lines_q  <= lines_q + 10'd1;
            end

            if (do_dec)
                scan_row <= scan_row - 5'd1;

            if (state == DONE && |board[0])
                game_over_q <= 1'b1;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.collision     = collision_q;
    assign bus.busy          = (state != IDLE);
    assign bus.line_pulse    = line_pulse_q;
    assign bus.lines_cleared = lines_q;
    assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_tetris_board.sv
// Directed bench for tetris_board: reset, collision, lock, row clears, game over and reset abort.
module tb_tetris_board;
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tetris_board_if #(.COLS(10)) bus ();

    tetris_board #(.COLS(10), .ROWS(20)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_sq(input logic [4:0] c1, r1, c2, r2, c3, r3, c4, r4);
        bus.sq_1_col = c1; bus.sq_1_row = r1;
        bus.sq_2_col = c2; bus.sq_2_row = r2;
        bus.sq_3_col = c3; bus.sq_3_row = r3;
        bus.sq_4_col = c4; bus.sq_4_row = r4;
    endtask

    task automatic park();
        set_sq(5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
    endtask

    task automatic read_row(input int r, output logic [9:0] d);
        bus.rd_row = 5'(r);
        tick();
        d = bus.rd_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Pulses lock_en with the squares already presented, then counts busy cycles and strobes.
    task automatic run_lock(input int relock_at, output int cyc, output int pulses);
        int base;
        bus.lock_en = 1'b1;
        tick();
        bus.lock_en = 1'b0;
        park();
        cyc    = 0;
        pulses = 0;
        base   = int'(bus.lines_cleared);
        while (bus.busy === 1'b1 && cyc < 100) begin
            if (bus.line_pulse === 1'b1) begin
                pulses++;
                checks++;
                if (bus.lines_cleared !== 10'(base + pulses)) begin
                    errors++;
                    $display("FAIL pulse_count_align: lines_cleared=%0d expected=%0d", bus.lines_cleared, base + pulses);
                end
            end
            if (cyc == relock_at) begin
                set_sq(5'd0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd3, 5'd0);
                bus.lock_en = 1'b1;
            end else begin
                park();
                bus.lock_en = 1'b0;
            end
            cyc++;
            tick();
        end
        bus.lock_en = 1'b0;
        park();
        if (cyc >= 100) begin
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        logic [9:0] d;
        do_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.line_pulse !== 1'b0 || bus.lines_cleared !== 10'd0 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b pulse=%b lines=%0d go=%b expected 0 0 0 0",
                     bus.busy, bus.line_pulse, bus.lines_cleared, bus.game_over);
        end
        for (int r = 0; r < 32; r++) begin
            read_row(r, d);
            checks++;
            if (d !== 10'd0) begin
                errors++;
                $display("FAIL reset_read row %0d: got %b expected 0", r, d);
            end
        end
        set_sq(5'd4, 5'd5, 5'd5, 5'd5, 5'd4, 5'd5, 5'd5, 5'd5);
        tick();
        checks++;
        if (bus.collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_collision: got %b expected 0", bus.collision);
        end
        park();
    endtask

    task automatic test_floor_collision();
        set_sq(5'd4, 5'd19, 5'd5, 5'd19, 5'd4, 5'd18, 5'd5, 5'd18);
        tick();
        checks++;
        if (bus.collision !== 1'b1) begin
            errors++;
            $display("FAIL floor_collision: got %b expected 1", bus.collision);
        end
        set_sq(5'd4, 5'd17, 5'd5, 5'd17, 5'd4, 5'd16, 5'd5, 5'd16);
        tick();
        checks++;
        if (bus.collision !== 1'b0) begin
            errors++;
            $display("FAIL free_collision: got %b expected 0", bus.collision);
        end
        park();
    endtask

    task automatic test_lock_stack();
        int cyc, pulses;
        logic [9:0] d;
        set_sq(5'd4, 5'd18, 5'd5, 5'd18, 5'd4, 5'd19, 5'd5, 5'd19);
        run_lock(-1, cyc, pulses);
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL lock_busy_len: got %0d expected 21", cyc);
        end
        read_row(18, d);
        checks++;
        if (d !== 10'b0000110000) begin
            errors++;
            $display("FAIL lock_row18: got %b expected 0000110000", d);
        end
        read_row(19, d);
        checks++;
        if (d !== 10'b0000110000) begin
            errors++;
            $display("FAIL lock_row19: got %b expected 0000110000", d);
        end
        set_sq(5'd4, 5'd16, 5'd5, 5'd16, 5'd4, 5'd17, 5'd5, 5'd17);
        tick();
        checks++;
        if (bus.collision !== 1'b1) begin
            errors++;
            $display("FAIL stack_collision: got %b expected 1", bus.collision);
        end
        park();
    endtask

    task automatic test_single_clear();
        int cyc, pulses;
        logic [9:0] d;
        do_reset();
        set_sq(5'd0, 5'd19, 5'd1, 5'd19, 5'd2, 5'd19, 5'd3, 5'd19);
        run_lock(-1, cyc, pulses);
        set_sq(5'd4, 5'd19, 5'd5, 5'd19, 5'd6, 5'd19, 5'd7, 5'd19);
        run_lock(-1, cyc, pulses);
        set_sq(5'd0, 5'd18, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
        run_lock(-1, cyc, pulses);
        set_sq(5'd8, 5'd18, 5'd9, 5'd18, 5'd8, 5'd19, 5'd9, 5'd19);
        run_lock(-1, cyc, pulses);
        checks++;
        if (cyc !== 22) begin
            errors++;
            $display("FAIL single_busy_len: got %0d expected 22", cyc);
        end
        checks++;
        if (pulses !== 1 || bus.lines_cleared !== 10'd1) begin
            errors++;
            $display("FAIL single_lines: pulses=%0d lines=%0d expected 1 1", pulses, bus.lines_cleared);
        end
        read_row(19, d);
        checks++;
        if (d !== 10'b1100000001) begin
            errors++;
            $display("FAIL single_row19: got %b expected 1100000001", d);
        end
        read_row(18, d);
        checks++;
        if (d !== 10'd0) begin
            errors++;
            $display("FAIL single_row18: got %b expected 0", d);
        end
    endtask

    task automatic test_double_clear();
        int cyc, pulses;
        logic [9:0] d;
        do_reset();
        set_sq(5'd0, 5'd19, 5'd1, 5'd19, 5'd2, 5'd19, 5'd3, 5'd19);
        run_lock(-1, cyc, pulses);
        set_sq(5'd4, 5'd19, 5'd5, 5'd19, 5'd6, 5'd19, 5'd7, 5'd19);
        run_lock(-1, cyc, pulses);
        set_sq(5'd0, 5'd18, 5'd1, 5'd18, 5'd2, 5'd18, 5'd3, 5'd18);
        run_lock(-1, cyc, pulses);
        set_sq(5'd4, 5'd18, 5'd5, 5'd18, 5'd6, 5'd18, 5'd7, 5'd18);
        run_lock(-1, cyc, pulses);
        set_sq(5'd8, 5'd18, 5'd9, 5'd18, 5'd8, 5'd19, 5'd9, 5'd19);
        run_lock(6, cyc, pulses);
        checks++;
        if (cyc !== 23) begin
            errors++;
            $display("FAIL double_busy_len: got %0d expected 23", cyc);
        end
        checks++;
        if (pulses !== 2 || bus.lines_cleared !== 10'd2) begin
            errors++;
            $display("FAIL double_lines: pulses=%0d lines=%0d expected 2 2", pulses, bus.lines_cleared);
        end
        for (int r = 0; r < 20; r++) begin
            read_row(r, d);
            checks++;
            if (d !== 10'd0) begin
                errors++;
                $display("FAIL double_grid row %0d: got %b expected 0", r, d);
            end
        end
        checks++;
        if (bus.game_over !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_lock: game_over=%b busy=%b expected 0 0", bus.game_over, bus.busy);
        end
    endtask

    task automatic test_game_over();
        int cyc, pulses;
        logic [9:0] d;
        set_sq(5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd3);
        bus.lock_en = 1'b1;
        tick();
        bus.lock_en = 1'b0;
        park();
        checks++;
        if (bus.game_over !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL go_early: game_over=%b busy=%b expected 0 1", bus.game_over, bus.busy);
        end
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        checks++;
        if (bus.game_over !== 1'b1 || cyc !== 21) begin
            errors++;
            $display("FAIL go_set: game_over=%b busy_cycles=%0d expected 1 21", bus.game_over, cyc);
        end
        set_sq(5'd5, 5'd19, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
        run_lock(-1, cyc, pulses);
        read_row(19, d);
        checks++;
        if (bus.game_over !== 1'b1 || d !== 10'b0000100000) begin
            errors++;
            $display("FAIL go_hold: game_over=%b row19=%b expected 1 0000100000", bus.game_over, d);
        end
    endtask

    task automatic test_reset_abort();
        logic [9:0] d;
        set_sq(5'd3, 5'd19, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
        bus.lock_en = 1'b1;
        tick();
        bus.lock_en = 1'b0;
        set_sq(5'd4, 5'd19, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
        bus.rd_row = 5'd19;
        tick();
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.rd_data !== 10'b0000101000 || bus.collision !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: busy=%b rd=%b coll=%b expected 1 0000101000 1",
                     bus.busy, bus.rd_data, bus.collision);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.line_pulse !== 1'b0 || bus.lines_cleared !== 10'd0 ||
            bus.game_over !== 1'b0 || bus.collision !== 1'b0 || bus.rd_data !== 10'd0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b pulse=%b lines=%0d go=%b coll=%b rd=%b expected all 0",
                     bus.busy, bus.line_pulse, bus.lines_cleared, bus.game_over, bus.collision, bus.rd_data);
        end
        rst = 1'b0;
        park();
        read_row(19, d);
        checks++;
        if (d !== 10'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_grid: row19=%b busy=%b expected 0 0", d, bus.busy);
        end
    endtask

    initial begin
        bus.lock_en = 1'b0;
        bus.rd_row  = 5'd0;
        park();
        tick();
        test_reset();
        test_floor_collision();
        test_lock_stack();
        test_single_clear();
        test_double_clear();
        test_game_over();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
